tdm_demux1to4: RTL and testbench

- Sequential 1-to-LANES time-division demultiplexer and deserializer. It is the receive end of a TDM link whose transmit end drives a single bit line through a 4-to-1 mux with a rolling 2-bit select.
- Distributes incoming serial slots onto a parallel lane word using an internal slot counter.
- Presents each completed frame with a one-cycle valid strobe.
- Realigns on an explicit SYNC marker.

---
 rtl/tdm_demux1to4.sv | 64 ++++++
 tb/tb_tdm_demux1to4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux1to4.sv
// TDM receive demux: deserializes a rolling-slot bit line into lane words.
// Optional macro TDM_SYNC_CHECK_EN enables the sticky early-sync ERR flag.
module tdm_demux1to4 #(
  parameter int LANES = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             D_VALID,
  input  logic             SYNC,
  output logic [SEL_W-1:0] S,
  output logic [LANES-1:0] Y,
  output logic             Y_VALID,
  output logic             ERR
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  // slots 0..LANES-2; the last slot goes straight into Y
  logic [LANES-2:0] shadow;
  logic             early;

  assign early = D_VALID & SYNC & (S != '0);

  // slot counter, frame assembly and completed-frame output
  always_ff @(posedge clk) begin
    if (rst) begin
      S       <= '0;
      shadow  <= '0;
      Y       <= '0;
      Y_VALID <= 1'b0;
    end else begin
      Y_VALID <= 1'b0;
      if (D_VALID) begin
        if (early) begin
          shadow <= {{(LANES-2){1'b0}}, D};
          S      <= ONE;
        end else if (S == LAST) begin
          Y       <= {D, shadow};
          Y_VALID <= 1'b1;
          S       <= '0;
        end else begin
          for (int i = 0; i < LANES - 1; i++) begin
            if (S == SEL_W'(i)) shadow[i] <= D;
          end
          S <= S + ONE;
        end
      end
    end
  end

`ifdef TDM_SYNC_CHECK_EN
  // sticky flag: any sync that lands off slot 0
  always_ff @(posedge clk) begin
    if (rst) ERR <= 1'b0;
    else if (early) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Scoreboard bench for tdm_demux1to4.
// Expected frames are queued by stimulus and checked by a monitor.
module tb_tdm_demux1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       D, D_VALID, SYNC;
  logic [1:0] S;
  logic [3:0] Y;
  logic       Y_VALID, ERR;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cyc = 0;
  int last_pulse = 0;
  int gap = 0;
  logic [3:0] exp_q[$];
  logic exp_err;

  tdm_demux1to4 #(.LANES(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .D(D), .D_VALID(D_VALID), .SYNC(SYNC),
    .S(S), .Y(Y), .Y_VALID(Y_VALID), .ERR(ERR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every Y_VALID pulse must match the oldest queued frame
  always @(negedge clk) begin
    if (!rst && Y_VALID === 1'b1) begin
      pulses++;
      gap = cyc - last_pulse;
      last_pulse = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got Y=%b expected no pulse", Y);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (Y !== e) begin
          errors++;
          $display("FAIL frame: got Y=%b expected %b", Y, e);
        end
      end
    end
  end

  task automatic send(input logic d, input logic v, input logic s);
    D = d; D_VALID = v; SYNC = s;
    @(posedge clk); #1;
    D = 1'b0; D_VALID = 1'b0; SYNC = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
`ifdef TDM_SYNC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    D = 0; D_VALID = 0; SYNC = 0; rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_S", S, 0);
    check("rst_Y", Y, 0);
    check("rst_YV", Y_VALID, 0);
    check("rst_ERR", ERR, 0);
    rst = 0;

    // 1: basic frame with sync on slot 0
    send(1, 1, 1);
    send(0, 1, 0);
    send(1, 1, 0);
    exp_q.push_back(4'b1101);
    send(1, 1, 0);
    check("t1_YV", Y_VALID, 1);
    check("t1_S", S, 0);
    check("t1_ERR", ERR, 0);
    idle(1);
    check("t1_YV_low", Y_VALID, 0);
    check("t1_q", exp_q.size(), 0);

    // 2: bubbles between slots
    send(1, 1, 1);
    idle(1);
    check("t2_S1", S, 1);
    send(0, 1, 0);
    idle(2);
    check("t2_S2", S, 2);
    send(1, 1, 0);
    idle(3);
    check("t2_S3", S, 3);
    check("t2_YV", Y_VALID, 0);
    exp_q.push_back(4'b1101);
    send(1, 1, 0);
    idle(2);
    check("t2_pulses", pulses, 2);

    // 3: back-to-back frames
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b1010);
    send(1, 1, 0); send(1, 1, 0); send(0, 1, 0); send(0, 1, 0);
    send(0, 1, 0); send(1, 1, 0); send(0, 1, 0); send(1, 1, 0);
    idle(1);
    check("t3_gap", gap, 4);
    check("t3_pulses", pulses, 4);

    // 4: early sync at S=2
    send(1, 1, 0);
    send(0, 1, 0);
    check("t4_S2", S, 2);
    send(1, 1, 1);
    check("t4_S_realign", S, 1);
    check("t4_YV", Y_VALID, 0);
    check("t4_ERR", ERR, exp_err);
    send(0, 1, 0);
    send(0, 1, 0);
    exp_q.push_back(4'b1001);
    send(1, 1, 0);
    idle(1);
    check("t4_pulses", pulses, 5);
    check("t4_ERR_sticky", ERR, exp_err);

    // 5: reset mid-frame
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 0);
    check("t5_S3", S, 3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("t5_S", S, 0);
    check("t5_Y", Y, 0);
    check("t5_YV", Y_VALID, 0);
    check("t5_ERR", ERR, 0);
    send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
    exp_q.push_back(4'b1111);
    send(1, 1, 0);
    idle(1);
    check("t5_pulses", pulses, 6);

    // 6: SYNC without D_VALID is ignored
    send(1, 1, 0);
    send(0, 1, 0);
    send(1, 0, 1);
    check("t6_S", S, 2);
    check("t6_ERR", ERR, 0);
    send(1, 1, 0);
    exp_q.push_back(4'b0101);
    send(0, 1, 0);
    idle(2);
    check("t6_Y_hold", Y, 4'b0101);
    check("t6_pulses", pulses, 7);
    check("end_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
